demux_1to8_deser: RTL and testbench

DEMUX_1TO8_DESER -- requirements
Module: demux_1to8_deser

---
 rtl/demux_1to8_deser.sv | 127 ++++++++++++
 tb/tb_demux_1to8_deser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to8_deser.sv
// 1-to-8 serial-to-parallel deserializer with valid/ready handshakes on both sides,
// a single-entry output slot and partial-word flush.
module demux_1to8_deser #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       flush,
    output logic [7:0] y,
    output logic       y_valid,
    input  logic       y_ready,
    output logic [3:0] y_count
);

    typedef enum logic {
        EMPTY   = 1'b0,
        FILLING = 1'b1
    } asm_state_e;

    asm_state_e state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] asm_q, asm_d;
    logic       flush_pend_q, flush_pend_d;
    logic [7:0] y_q, y_d;
    logic [3:0] y_count_q, y_count_d;
    logic       y_valid_q, y_valid_d;

    logic       slot_free;
    logic       din_ready_c;
    logic       accept;
    logic [2:0] wr_pos;
    logic [7:0] asm_wr;
    logic [3:0] fill_eff;
    logic       fill_nz;
    logic       word_done;
    logic       flush_req;
    logic       flush_ok;
    logic       load;

    always_comb begin
        slot_free   = !y_valid_q || y_ready;
        // Only the 8th bit needs somewhere to go; earlier bits always fit in asm.
        din_ready_c = !((idx_q == 3'd7) && !slot_free);
        accept      = din_valid && din_ready_c;
        wr_pos      = MSB_FIRST ? (3'd7 - idx_q) : idx_q;

        asm_wr = asm_q;
        if (accept) begin
            asm_wr[wr_pos] = din;
        end

        fill_eff  = {1'b0, idx_q} + {3'b000, accept};
        fill_nz   = (state_q == FILLING) || accept;
        word_done = accept && (idx_q == 3'd7);
        flush_req = flush || flush_pend_q;
        flush_ok  = flush_req && slot_free && fill_nz;
        // A flush that coincides with the 8th bit collapses into the same single load.
        load      = word_done || flush_ok;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        y_d       = y_q;
        y_count_d = y_count_q;
        y_valid_d = y_valid_q;
        // Pending survives only while there is something to emit and no load happened.
        flush_pend_d = flush_req && fill_nz && !load;

        if (load) begin
            y_d       = asm_wr;
            y_count_d = fill_eff;
            y_valid_d = 1'b1;
            idx_d     = 3'd0;
            asm_d     = 8'h00;
            state_d   = EMPTY;
        end else begin
            if (y_valid_q && y_ready) begin
                y_valid_d = 1'b0;
            end
            if (accept) begin
                idx_d   = idx_q + 3'd1;
                asm_d   = asm_wr;
                state_d = FILLING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            idx_q        <= 3'd0;
            asm_q        <= 8'h00;
            flush_pend_q <= 1'b0;
            y_q          <= 8'h00;
            y_count_q    <= 4'd0;
            y_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            flush_pend_q <= flush_pend_d;
            y_q          <= y_d;
            y_count_q    <= y_count_d;
            y_valid_q    <= y_valid_d;
        end
    end

    assign din_ready = din_ready_c;
    assign y         = y_q;
    assign y_count   = y_count_q;
    assign y_valid   = y_valid_q;

    a_slot_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (y_valid_q && !y_ready) |=> (y_valid_q && $stable(y_q) && $stable(y_count_q)));

    a_state_idx: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == EMPTY) == (idx_q == 3'd0)));

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        y_valid_q |-> ((y_count_q != 4'd0) && (y_count_q <= 4'd8)));

endmodule

// File: tb/tb_demux_1to8_deser.sv
// Scoreboard bench for demux_1to8_deser: LSB-first and MSB-first instances share stimulus,
// and each consumed word is compared against hand-computed expectations for both orders.
module tb_demux_1to8_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       flush;
    logic       y_ready;

    logic       din_ready0, din_ready1;
    logic [7:0] y0, y1;
    logic       y_valid0, y_valid1;
    logic [3:0] cnt0, cnt1;

    always #5 clk = ~clk;

    demux_1to8_deser #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready0),
        .flush(flush), .y(y0), .y_valid(y_valid0), .y_ready(y_ready), .y_count(cnt0)
    );

    demux_1to8_deser #(.MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready1),
        .flush(flush), .y(y1), .y_valid(y_valid1), .y_ready(y_ready), .y_count(cnt1)
    );

    typedef struct packed {
        logic [7:0] w_lsb;
        logic [7:0] w_msb;
        logic [3:0] c;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_word(input logic [7:0] wl, input logic [7:0] wm, input logic [3:0] c);
        exp_t e;
        e.w_lsb = wl;
        e.w_msb = wm;
        e.c     = c;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] v);
        for (int k = 0; k < 8; k++) send_bit(v[k]);
    endtask

    // Monitor: a word is consumed on the coming edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && y_valid0 && y_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got y=%0h cnt=%0d, expected no word (t=%0t)", y0, cnt0, $time);
            end else begin
                mon_e = q.pop_front();
                check("word_y_lsb", {24'd0, y0}, {24'd0, mon_e.w_lsb});
                check("word_cnt_lsb", {28'd0, cnt0}, {28'd0, mon_e.c});
                check("word_valid_msb", {31'd0, y_valid1}, 32'd1);
                check("word_y_msb", {24'd0, y1}, {24'd0, mon_e.w_msb});
                check("word_cnt_msb", {28'd0, cnt1}, {28'd0, mon_e.c});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; flush = 1'b0; y_ready = 1'b1;

        // Reset state
        #2;
        check("rst_y", {24'd0, y0}, 32'h00);
        check("rst_cnt", {28'd0, cnt0}, 32'd0);
        check("rst_valid", {31'd0, y_valid0}, 32'd0);
        check("rst_din_ready", {31'd0, din_ready0}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic stream 1,0,1,1,0,0,1,0
        expect_word(8'h4D, 8'hB2, 4'd8);
        send_word(8'h4D);
        check("basic_valid_after_8th", {31'd0, y_valid0}, 32'd1);
        check("basic_cnt", {28'd0, cnt0}, 32'd8);
        tick();
        check("basic_valid_one_cycle", {31'd0, y_valid0}, 32'd0);

        // Back-to-back words, no bubbles
        expect_word(8'h12, 8'h48, 4'd8);
        expect_word(8'h6B, 8'hD6, 4'd8);
        for (int w = 0; w < 2; w++) begin
            v = (w == 0) ? 8'h12 : 8'h6B;
            for (int k = 0; k < 8; k++) begin
                check("stream_din_ready", {31'd0, din_ready0}, 32'd1);
                send_bit(v[k]);
            end
        end
        tick();

        // Backpressure: full slot, 7 more bits accepted, 8th stalls
        y_ready = 1'b0;
        expect_word(8'h5C, 8'h3A, 4'd8);
        send_word(8'h5C);
        check("bp_slot_full", {31'd0, y_valid0}, 32'd1);
        v = 8'hC1;
        for (int k = 0; k < 7; k++) begin
            check("bp_din_ready_early", {31'd0, din_ready0}, 32'd1);
            send_bit(v[k]);
        end
        check("bp_din_ready_low", {31'd0, din_ready0}, 32'd0);
        check("bp_din_ready_low_msb", {31'd0, din_ready1}, 32'd0);
        din = v[7];
        din_valid = 1'b1;
        tick();
        check("bp_still_stalled", {31'd0, din_ready0}, 32'd0);
        check("bp_y_held", {24'd0, y0}, 32'h5C);
        expect_word(8'hC1, 8'h83, 4'd8);
        y_ready = 1'b1;
        #1;
        check("bp_din_ready_comb", {31'd0, din_ready0}, 32'd1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        check("bp_second_word", {24'd0, y0}, 32'hC1);
        check("bp_second_valid", {31'd0, y_valid0}, 32'd1);
        check("bp_din_ready_back", {31'd0, din_ready0}, 32'd1);
        tick();

        // Flush of a 3-bit partial word
        expect_word(8'h03, 8'hC0, 4'd3);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush3_valid", {31'd0, y_valid0}, 32'd1);
        check("flush3_cnt", {28'd0, cnt0}, 32'd3);
        tick();

        // Flush with nothing assembled is dropped
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty_no_word", {31'd0, y_valid0}, 32'd0);
        tick();
        check("flush_empty_no_late_word", {31'd0, y_valid0}, 32'd0);

        // Flush on the 8th bit gives one full word
        expect_word(8'h96, 8'h69, 4'd8);
        v = 8'h96;
        for (int k = 0; k < 7; k++) send_bit(v[k]);
        flush = 1'b1;
        send_bit(v[7]);
        flush = 1'b0;
        check("flush8_valid", {31'd0, y_valid0}, 32'd1);
        check("flush8_cnt", {28'd0, cnt0}, 32'd8);
        tick();
        check("flush8_single", {31'd0, y_valid0}, 32'd0);
        tick();
        check("flush8_no_residual", {31'd0, y_valid0}, 32'd0);

        // Flush while slot is held stays pending
        y_ready = 1'b0;
        expect_word(8'h11, 8'h88, 4'd8);
        send_word(8'h11);
        send_bit(1'b1); send_bit(1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("pend_y_held", {24'd0, y0}, 32'h11);
        check("pend_cnt_held", {28'd0, cnt0}, 32'd8);
        expect_word(8'h01, 8'h80, 4'd2);
        y_ready = 1'b1;
        tick();
        check("pend_partial_y", {24'd0, y0}, 32'h01);
        check("pend_partial_cnt", {28'd0, cnt0}, 32'd2);
        check("pend_partial_valid", {31'd0, y_valid0}, 32'd1);
        tick();
        check("pend_done", {31'd0, y_valid0}, 32'd0);

        // Asynchronous reset mid-word with a held word
        y_ready = 1'b0;
        send_word(8'hFF);
        for (int k = 0; k < 5; k++) send_bit(1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_y", {24'd0, y0}, 32'h00);
        check("arst_y_msb", {24'd0, y1}, 32'h00);
        check("arst_cnt", {28'd0, cnt0}, 32'd0);
        check("arst_valid", {31'd0, y_valid0}, 32'd0);
        check("arst_din_ready", {31'd0, din_ready0}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        y_ready = 1'b1;
        tick();
        tick();
        check("arst_no_word_after", {31'd0, y_valid0}, 32'd0);
        expect_word(8'h35, 8'hAC, 4'd8);
        send_word(8'h35);
        tick();
        expect_word(8'h02, 8'h40, 4'd3);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();

        check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
